// File: rtl/bcd_display_scanner.sv
// rtl/bcd_display_scanner.sv - binary to BCD double-dabble converter with 4-digit multiplexed scan
module bcd_display_scanner #(
    parameter int VALUE_W     = 14,
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               value_valid,
    output logic               busy,
    output logic               overflow,
    output logic [3:0]         selected_digit_data,
    output logic [3:0]         anode
);

    localparam int CW = (VALUE_W > 1) ? $clog2(VALUE_W) : 1;
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(VALUE_W - 1);
    localparam logic [PW-1:0] LAST_PRE  = PW'(REFRESH_DIV - 1);
    localparam logic [31:0]   MAX_BCD   = 32'd9999;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    state_t             r_state;
    logic [VALUE_W-1:0] r_bin;
    logic [15:0]        r_bcd;
    logic [15:0]        r_display;
    logic [CW-1:0]      r_iter;
    logic [PW-1:0]      r_pre;
    logic [1:0]         r_idx;

    logic [15:0]        w_adj;
    logic               w_sat;
    logic [VALUE_W-1:0] w_load;
    logic [3:0]         w_digit;
    logic [3:0]         w_blank;

    for (genvar k = 0; k < 4; k++) begin : g_add3
        assign w_adj[k*4 +: 4] = (r_bcd[k*4 +: 4] >= 4'd5) ? r_bcd[k*4 +: 4] + 4'd3
                                                           : r_bcd[k*4 +: 4];
    end

    assign w_sat  = 32'(value_in) > MAX_BCD;
    assign w_load = w_sat ? VALUE_W'(MAX_BCD) : value_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            r_bin     <= '0;
            r_bcd     <= '0;
            r_iter    <= '0;
            r_display <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (value_valid) begin
                        r_bin    <= w_load;
                        r_bcd    <= '0;
                        overflow <= w_sat;
                        r_iter   <= '0;
                        busy     <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_adj, r_bin} << 1;
                    r_iter         <= r_iter + CW'(1);
                    if (r_iter == LAST_ITER) begin
                        r_state <= COMMIT;
                    end
                end
                COMMIT: begin
                    // Only place the shown value changes, so the scan never sees a partial result
                    r_display <= r_bcd;
                    busy      <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_digit    = r_display[{r_idx, 2'b00} +: 4];
    assign w_blank[0] = 1'b0;
    assign w_blank[3] = BLANK_LZ && (r_display[15:12] == 4'd0);
    assign w_blank[2] = w_blank[3] && (r_display[11:8] == 4'd0);
    assign w_blank[1] = w_blank[2] && (r_display[7:4] == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pre               <= '0;
            r_idx               <= 2'd0;
            selected_digit_data <= 4'd0;
            anode               <= 4'b1111;
        end else begin
            if (r_pre == LAST_PRE) begin
                r_pre <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
            selected_digit_data <= w_digit;
            anode               <= w_blank[r_idx] ? 4'b1111 : ~(4'b0001 << r_idx);
        end
    end

endmodule
